// File: rtl/branch_resolve_pkg.sv
// Shared instruction types plus the branch-resolution additions.
package branch_resolve_pkg;

  localparam int unsigned PC_W = 32;

  typedef logic [PC_W-1:0] program_counter_t;

  typedef enum logic [2:0] {
    OP_BRU_BEQ,
    OP_BRU_BNE,
    OP_BRU_BLT,
    OP_BRU_BGE,
    OP_BRU_BLTU,
    OP_BRU_BGEU,
    OP_BRU_JAL,
    OP_BRU_JALR
  } decode_bru_op_t;

  // Predictor/fetch update record for one resolved branch.
  typedef struct packed {
    program_counter_t pc;
    program_counter_t target;
    logic             taken;
    logic             is_jalr;
    logic             mispred;
  } branch_update_t;

  typedef enum logic {
    RSV_IDLE,
    RSV_REDIRECT
  } resolve_state_t;

endpackage

// File: rtl/branch_resolve_wrap_counter.sv
// Free-running wrapping event counter.
module wrap_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  // Increment on enable; overflow wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: registers outcomes, detects mispredicts, holds redirects.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned TAG_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_e,
  input  decode_bru_op_t   i_op,
  input  program_counter_t i_pc,
  input  logic [TAG_W-1:0] i_tag,
  input  program_counter_t i_dest_pc,
  input  logic             i_taken,
  input  program_counter_t i_pred_pc,
  input  logic             i_pred_taken,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_redirect_valid,
  output program_counter_t o_redirect_pc,
  output logic [TAG_W-1:0] o_redirect_tag,
  input  logic             i_redirect_ready,
  output logic             o_upd_valid,
  output program_counter_t o_upd_pc,
  output program_counter_t o_upd_target,
  output logic             o_upd_taken,
  output logic             o_upd_is_jalr,
  output logic             o_upd_mispred,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  resolve_state_t state_q;
  resolve_state_t state_d;
  logic           capture_c;
  logic           mispred_c;
  branch_update_t upd_q;

  // Predicted-taken is informational only; the PC compare decides mispredicts.
  logic unused_pred_taken;
  assign unused_pred_taken = i_pred_taken;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RSV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and capture decision; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    mispred_c = (i_dest_pc != i_pred_pc);
    if (i_flush) begin
      state_d = RSV_IDLE;
    end else begin
      case (state_q)
        RSV_IDLE: begin
          capture_c = i_e;
          if (i_e && mispred_c) begin
            state_d = RSV_REDIRECT;
          end
        end
        RSV_REDIRECT: begin
          if (i_redirect_ready) begin
            state_d = RSV_IDLE;
          end
        end
        default: state_d = RSV_IDLE;
      endcase
    end
  end

  // Stall is a pure decode of state so it never depends on same-cycle inputs.
  assign o_stall = (state_q == RSV_REDIRECT);

  // Redirect request registers; target and tag hold while the request waits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_redirect_tag   <= '0;
    end else begin
      o_redirect_valid <= (state_d == RSV_REDIRECT);
      if (capture_c && mispred_c) begin
        o_redirect_pc  <= i_dest_pc;
        o_redirect_tag <= i_tag;
      end
    end
  end

  // One-cycle predictor update record per captured branch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_upd_valid <= 1'b0;
      upd_q       <= '0;
    end else begin
      o_upd_valid <= capture_c;
      if (capture_c) begin
        upd_q.pc      <= i_pc;
        upd_q.target  <= i_dest_pc;
        upd_q.taken   <= i_taken;
        upd_q.is_jalr <= (i_op == OP_BRU_JALR);
        upd_q.mispred <= mispred_c;
      end
    end
  end

  assign o_upd_pc      = upd_q.pc;
  assign o_upd_target  = upd_q.target;
  assign o_upd_taken   = upd_q.taken;
  assign o_upd_is_jalr = upd_q.is_jalr;
  assign o_upd_mispred = upd_q.mispred;

  // Resolved-branch and mispredict statistics.
  wrap_counter #(.W(CNT_W)) u_branch_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (capture_c),
    .o_cnt   (o_branch_cnt)
  );

  wrap_counter #(.W(CNT_W)) u_mispred_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (capture_c && mispred_c),
    .o_cnt   (o_mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve; a CNT_W=4 twin checks counter wrap.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             e = 1'b0;
  decode_bru_op_t   op = OP_BRU_BEQ;
  program_counter_t pc = '0;
  logic [5:0]       tag = '0;
  program_counter_t dest = '0;
  logic             tk = 1'b0;
  program_counter_t pred = '0;
  logic             ptk = 1'b0;
  logic             flush = 1'b0;
  logic             rdy = 1'b0;

  logic             stall, rv, upd_v, upd_tk, upd_j, upd_m;
  program_counter_t rpc, upd_pc, upd_tgt;
  logic [5:0]       rtag;
  logic [31:0]      bcnt, mcnt;

  logic             d4_stall, d4_rv, d4_upd_v, d4_upd_tk, d4_upd_j, d4_upd_m;
  program_counter_t d4_rpc, d4_upd_pc, d4_upd_tgt;
  logic [5:0]       d4_rtag;
  logic [3:0]       d4_bcnt, d4_mcnt;

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(32), .TAG_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_op(op), .i_pc(pc), .i_tag(tag),
    .i_dest_pc(dest), .i_taken(tk), .i_pred_pc(pred), .i_pred_taken(ptk),
    .i_flush(flush), .o_stall(stall), .o_redirect_valid(rv),
    .o_redirect_pc(rpc), .o_redirect_tag(rtag), .i_redirect_ready(rdy),
    .o_upd_valid(upd_v), .o_upd_pc(upd_pc), .o_upd_target(upd_tgt),
    .o_upd_taken(upd_tk), .o_upd_is_jalr(upd_j), .o_upd_mispred(upd_m),
    .o_branch_cnt(bcnt), .o_mispred_cnt(mcnt)
  );

  branch_resolve #(.CNT_W(4), .TAG_W(6)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_op(op), .i_pc(pc), .i_tag(tag),
    .i_dest_pc(dest), .i_taken(tk), .i_pred_pc(pred), .i_pred_taken(ptk),
    .i_flush(flush), .o_stall(d4_stall), .o_redirect_valid(d4_rv),
    .o_redirect_pc(d4_rpc), .o_redirect_tag(d4_rtag), .i_redirect_ready(rdy),
    .o_upd_valid(d4_upd_v), .o_upd_pc(d4_upd_pc), .o_upd_target(d4_upd_tgt),
    .o_upd_taken(d4_upd_tk), .o_upd_is_jalr(d4_upd_j), .o_upd_mispred(d4_upd_m),
    .o_branch_cnt(d4_bcnt), .o_mispred_cnt(d4_mcnt)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        jalr;
    logic        mis;
  } exp_upd_t;

  exp_upd_t    upd_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  // Reference model: "cur" is what the outputs should show this cycle,
  // "nxt" is what they should show after the coming edge.
  bit          cur_pend, nxt_pend;
  logic [31:0] cur_rpc, nxt_rpc;
  logic [5:0]  cur_rtag, nxt_rtag;
  int unsigned cur_b, nxt_b, cur_m, nxt_m;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
  endtask

  task automatic model_clear();
    cur_pend = 0; nxt_pend = 0; cur_rpc = '0; nxt_rpc = '0;
    cur_rtag = '0; nxt_rtag = '0; cur_b = 0; nxt_b = 0; cur_m = 0; nxt_m = 0;
    upd_q.delete();
  endtask

  // Drive one cycle of stimulus and record what the model expects afterwards.
  task automatic step(input logic e_i, input decode_bru_op_t op_i, input logic [31:0] pc_i,
                      input logic [5:0] tag_i, input logic [31:0] dest_i,
                      input logic [31:0] pred_i, input logic tk_i,
                      input logic rdy_i, input logic fl_i);
    exp_upd_t x;
    bit cap;
    @(posedge clk); #1;
    cur_pend = nxt_pend; cur_rpc = nxt_rpc; cur_rtag = nxt_rtag;
    cur_b = nxt_b; cur_m = nxt_m;
    e = e_i; op = op_i; pc = pc_i; tag = tag_i; dest = dest_i; pred = pred_i;
    tk = tk_i; ptk = ~tk_i; rdy = rdy_i; flush = fl_i;
    cap = !cur_pend && e_i && !fl_i;
    if (cap) begin
      nxt_b = cur_b + 1;
      x.cyc = cyc + 1; x.pc = pc_i; x.tgt = dest_i; x.taken = tk_i;
      x.jalr = (op_i == OP_BRU_JALR); x.mis = (dest_i != pred_i);
      upd_q.push_back(x);
      if (dest_i != pred_i) begin
        nxt_m = cur_m + 1; nxt_pend = 1; nxt_rpc = dest_i; nxt_rtag = tag_i;
      end
    end else if (cur_pend && rdy_i) begin
      nxt_pend = 0;
    end
    if (fl_i) nxt_pend = 0;
  endtask

  task automatic idle(input logic rdy_i);
    step(1'b0, OP_BRU_BEQ, 32'h0, 6'h0, 32'h0, 32'h0, 1'b0, rdy_i, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever an update is due and checks state outputs.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (upd_q.size() > 0 && upd_q[0].cyc <= cyc) begin
        exp_upd_t x;
        x = upd_q.pop_front();
        chk("upd_valid_due", {63'b0, upd_v}, 64'd1);
        chk("upd_cycle", 64'(cyc), 64'(x.cyc));
        chk("upd_pc", {32'b0, upd_pc}, {32'b0, x.pc});
        chk("upd_target", {32'b0, upd_tgt}, {32'b0, x.tgt});
        chk("upd_taken", {63'b0, upd_tk}, {63'b0, x.taken});
        chk("upd_is_jalr", {63'b0, upd_j}, {63'b0, x.jalr});
        chk("upd_mispred", {63'b0, upd_m}, {63'b0, x.mis});
      end else begin
        chk("upd_valid_quiet", {63'b0, upd_v}, 64'd0);
      end
      chk("stall", {63'b0, stall}, {63'b0, cur_pend});
      chk("redirect_valid", {63'b0, rv}, {63'b0, cur_pend});
      if (cur_pend) begin
        chk("redirect_pc", {32'b0, rpc}, {32'b0, cur_rpc});
        chk("redirect_tag", {58'b0, rtag}, {58'b0, cur_rtag});
      end
      chk("branch_cnt", {32'b0, bcnt}, {32'b0, cur_b});
      chk("mispred_cnt", {32'b0, mcnt}, {32'b0, cur_m});
      chk("branch_cnt_w4", {60'b0, d4_bcnt}, 64'(cur_b % 16));
      chk("mispred_cnt_w4", {60'b0, d4_mcnt}, 64'(cur_m % 16));
    end
  end

  task automatic chk_all_zero(input string tagname);
    chk({tagname, "_stall"}, {63'b0, stall}, 64'd0);
    chk({tagname, "_rv"}, {63'b0, rv}, 64'd0);
    chk({tagname, "_rpc"}, {32'b0, rpc}, 64'd0);
    chk({tagname, "_rtag"}, {58'b0, rtag}, 64'd0);
    chk({tagname, "_updv"}, {63'b0, upd_v}, 64'd0);
    chk({tagname, "_upd_data"}, {upd_pc, upd_tgt} | {61'b0, upd_tk, upd_j, upd_m}, 64'd0);
    chk({tagname, "_bcnt"}, {32'b0, bcnt}, 64'd0);
    chk({tagname, "_mcnt"}, {32'b0, mcnt}, 64'd0);
  endtask

  initial begin
    logic [31:0] p, d;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Correct prediction.
    step(1, OP_BRU_BEQ, 32'h100, 6'd1, 32'h104, 32'h104, 0, 0, 0);
    idle(0); idle(0);

    // Mispredict with ready low 3 cycles; i_e pulses during stall are ignored.
    step(1, OP_BRU_JAL, 32'h200, 6'd5, 32'h280, 32'h204, 1, 0, 0);
    step(1, OP_BRU_BNE, 32'h300, 6'd6, 32'h310, 32'h304, 1, 0, 0);
    idle(0);
    step(1, OP_BRU_BEQ, 32'h400, 6'd7, 32'h404, 32'h404, 0, 0, 0);
    idle(1);
    idle(0);

    // Back-to-back correct branches then a 1-cycle redirect.
    for (int i = 0; i < 4; i++)
      step(1, OP_BRU_BLT, 32'h500 + 32'(i * 4), 6'(i), 32'h600, 32'h600, 1, 0, 0);
    step(1, OP_BRU_JALR, 32'h510, 6'd9, 32'h900, 32'h514, 1, 0, 0);
    idle(1);
    step(1, OP_BRU_BGE, 32'h520, 6'd10, 32'h524, 32'h524, 0, 0, 0);
    idle(0);

    // Flush during redirect, flush with simultaneous ready, flush with i_e.
    step(1, OP_BRU_BNE, 32'h700, 6'd11, 32'h740, 32'h704, 1, 0, 0);
    idle(0);
    step(0, OP_BRU_BEQ, 0, 0, 0, 0, 0, 0, 1);
    step(1, OP_BRU_BNE, 32'h710, 6'd12, 32'h750, 32'h714, 1, 0, 1);
    step(1, OP_BRU_BEQ, 32'h720, 6'd13, 32'h724, 32'h724, 0, 0, 1);
    step(1, OP_BRU_BLTU, 32'h730, 6'd14, 32'h760, 32'h734, 1, 0, 0);
    step(0, OP_BRU_BEQ, 0, 0, 0, 0, 0, 1, 1);
    idle(0);

    // Asynchronous reset in the middle of a redirect.
    step(1, OP_BRU_JAL, 32'h800, 6'd21, 32'h880, 32'h804, 1, 0, 0);
    idle(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_clear();
    e = 1'b0; flush = 1'b0; rdy = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Randomized traffic; many more than 16 branches so the 4-bit twin wraps.
    for (int i = 0; i < 400; i++) begin
      p = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 99) < 70), decode_bru_op_t'($urandom_range(0, 7)), p,
           6'($urandom), ($urandom_range(0, 99) < 70) ? p + 32'd4 : d, p + 32'd4,
           1'($urandom), ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 5));
    end
    idle(1); idle(1); idle(0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("scoreboard_empty", 64'(upd_q.size()), 64'd0);
    chk("wrap_seen", 64'(nxt_b >= 17), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolution stage directly downstream of the branch unit. It registers each branch/jump outcome (destination PC, taken) and compares it with the next-PC the front end predicted. On a mismatch it raises a held redirect request to fetch until fetch accepts it, and stalls the branch unit meanwhile. It also emits a one-cycle predictor-update record and maintains branch/mispredict counters.

## Interface
Parameters:
- CNT_W, 32, width of the statistics counters
- TAG_W, 6, width of the instruction sequence tag carried with each branch

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_e  in  1  branch result valid this cycle
- i_op  in  decode_bru_op_t  branch opcode
- i_pc  in  program_counter_t  PC of the branch
- i_tag  in  TAG_W  sequence tag of the branch
- i_dest_pc  in  program_counter_t  resolved next PC
- i_taken  in  1  resolved taken
- i_pred_pc  in  program_counter_t  front-end predicted next PC
- i_pred_taken  in  1  front-end predicted taken
- i_flush  in  1  global pipeline flush from commit
- o_stall  out  1  branch unit must hold its current result
- o_redirect_valid  out  1  redirect request to fetch
- o_redirect_pc  out  program_counter_t  redirect target
- o_redirect_tag  out  TAG_W  tag of the mispredicted branch; younger instructions get killed
- i_redirect_ready  in  1  fetch accepts redirect
- o_upd_valid  out  1  predictor update pulse
- o_upd_pc  out  program_counter_t  branch PC
- o_upd_target  out  program_counter_t  resolved dest PC
- o_upd_taken  out  1  resolved taken
- o_upd_is_jalr  out  1  op was OP_BRU_JALR
- o_upd_mispred  out  1  dest PC differed from prediction
- o_branch_cnt  out  CNT_W  resolved branches
- o_mispred_cnt  out  CNT_W  mispredicts

## Operation
- States: IDLE and REDIRECT.
- In IDLE, if i_e=1 and i_flush=0, the result is captured at the clock edge.
- mispred = (i_dest_pc != i_pred_pc). The full 32-bit compare is the only criterion. i_pred_taken is informational and forwarded nowhere.
- Every captured branch:
  - produces o_upd_* with o_upd_valid=1 for exactly the next cycle;
  - increments o_branch_cnt, wrapping at 2^CNT_W;
  - if mispred, also increments o_mispred_cnt (wrapping) and moves to REDIRECT with o_redirect_pc=i_dest_pc and o_redirect_tag=i_tag.
- In REDIRECT:
  - o_redirect_valid=1; o_redirect_pc and o_redirect_tag are stable;
  - o_stall=1, and i_e is ignored because those results are wrong-path or held upstream;
  - on i_redirect_ready=1, return to IDLE at that edge.
- o_stall = (state==REDIRECT). It is combinational from state only, never from inputs.
- i_flush=1 in any state:
  - next state IDLE; pending redirect dropped;
  - any capture in that cycle suppressed, so no update and no count;
  - an o_upd_valid already being driven in that cycle still completes.
- Simultaneous i_flush and i_redirect_ready: flush wins. Result is the same, IDLE.
- Reset values: state IDLE, o_redirect_valid 0, o_redirect_pc 0, o_redirect_tag 0, o_upd_valid 0, all o_upd_* data 0, both counters 0, o_stall 0.

## Timing
- Capture at edge N. o_upd_valid is high during cycle N+1.
- On mispredict, o_redirect_valid rises in cycle N+1 and stays high through the cycle in which i_redirect_ready=1. It is low in the following cycle.
- Minimum redirect occupancy is 1 cycle, when ready is already high in N+1.
- A correctly predicted branch never asserts o_stall. Back-to-back results in consecutive cycles are accepted at full rate.
- Once a redirect has been accepted, a new result can be captured in the same cycle that o_stall falls.
- Counters update at the capture edge and are visible in cycle N+1.
- Reset is asynchronous: asserting i_rst_n mid-REDIRECT clears all outputs immediately, without waiting for a clock.

## Structure
- decode_bru_op_t and program_counter_t come from the existing shared instruction package.
- Add branch_update_t (pc, target, taken, is_jalr, mispred) to that package; fetch and the predictor consume it.
- Add a resolve-state enum (RSV_IDLE, RSV_REDIRECT) to the same package.
- One sub-module: wrap_counter (CNT_W-bit, increment enable, async active-low reset), instantiated twice.

## Test plan
- Correct predictions: pc 0x100 BEQ, dest 0x104, pred 0x104 -> upd_valid pulse with mispred=0; no redirect; branch_cnt=1, mispred_cnt=0; o_stall stays 0.
- Mispredict with ready held low 3 cycles: JAL at 0x200, dest 0x280, pred 0x204, tag 5.
  - Redirect valid with pc 0x280 and tag 5 for 4 cycles; o_stall=1 throughout.
  - i_e pulses during the stall are ignored; counts stay 1/1.
- Back-to-back: 4 consecutive correct branches, then a mispredict with ready=1 in N+1 -> 5 upd pulses, one 1-cycle redirect, counts 5/1.
- Flush during REDIRECT and flush with simultaneous i_e: redirect drops the next cycle; the flushed branch produces no update and no count.
- Async reset mid-REDIRECT and counter wrap:
  - Asserting i_rst_n low mid-REDIRECT zeroes all outputs before the next edge.
  - With CNT_W=4, 17 branches -> branch_cnt=1.
